uart_tx_arbiter: RTL
====================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter BUSY_TO, default 16: cycles to wait for tx_busy to rise after tx_start before declaring a timeout.
REQ-002 Port clk input 1: system clock; every register is clocked on its rising edge.
REQ-003 Port rst input 1: reset, synchronous and active-high.
REQ-004 Port en input 1: when 1, new grants are allowed; when 0, no new grant is issued and a transfer already in progress completes.
REQ-005 Port req input 4: req[i]=1 means requester i has one byte to send.
REQ-006 Port req_data input 32: byte for requester i on bits [8i+7:8i].
REQ-007 Port tx_busy input 1: busy flag from the UART transmitter.
REQ-008 Port tx_data output 8: byte presented to the UART transmitter.
REQ-009 Port tx_start output 1: one-cycle start pulse to the UART transmitter.
REQ-010 Port ack output 4: one-cycle pulse to the requester whose byte was taken.
REQ-011 Port grant_id output 2: index of the last granted requester.
REQ-012 Port arb_busy output 1: 1 in every state except IDLE.
REQ-013 Port err_timeout output 1: sticky error flag.
REQ-014 Port byte_count output 16: count of completed bytes.

Function
REQ-015 The FSM shall have exactly the states IDLE, START, WAIT_HI, WAIT_LO and GAP; any other encoding shall go to IDLE on the next cycle.
REQ-016 In IDLE with en=1 and req!=0, the block shall choose g round-robin, searching from (last_grant+1) mod 4 upward and wrapping.
REQ-017 On that same edge the block shall set tx_data=req_data[g], tx_start=1, ack[g]=1 and grant_id=g, and enter START.
REQ-018 Only one ack bit shall be high at any time.
REQ-019 In START the block shall clear tx_start and ack, clear the timeout counter, and enter WAIT_HI; tx_start and ack are therefore high for exactly 1 cycle.
REQ-020 In WAIT_HI with tx_busy=1 the block shall enter WAIT_LO.
REQ-021 In WAIT_HI with tx_busy=0 the timeout counter shall increment.
REQ-022 When the counter reaches BUSY_TO-1 with tx_busy still 0, the block shall set err_timeout=1, leave byte_count unchanged, and enter IDLE.
REQ-023 In WAIT_LO with tx_busy=0 the block shall increment byte_count, wrapping 0xFFFF to 0x0000, and enter GAP.
REQ-024 GAP shall last 1 cycle and then enter IDLE, giving at least 1 idle cycle between start pulses.
REQ-025 Requesters shall hold req and req_data stable until their ack; req is sampled only in IDLE.
REQ-026 A req that drops before its ack is lost silently, with no ack and no error.
REQ-027 A req dropped on the edge where ack is issued shall not be granted again.
REQ-028 When en falls mid-transfer, the transfer shall run to GAP and the FSM shall then stay in IDLE.
REQ-029 tx_data shall hold its value between grants.
REQ-030 err_timeout shall clear only on rst.
REQ-031 Byte latency from req seen in IDLE to tx_start shall be 1 cycle.

Reset
REQ-032 When rst=1 at a clock edge, the block shall go to IDLE and set tx_start=0, ack=0, tx_data=0x00, grant_id=3 (last_grant=3, so req0 has priority first), byte_count=0, err_timeout=0, arb_busy=0, and timeout counter=0.
REQ-033 Reset shall take precedence over every other input, including in mid-transfer.
REQ-034 A transfer aborted by reset shall not be counted and shall not be acked again.

Verification
REQ-035 Single requester: req=0001, data 0x41, model tx_busy high 3 cycles after tx_start -> one tx_start with tx_data=0x41, ack=0001 for 1 cycle, byte_count=1.
REQ-036 Round-robin: req=1111 held, data 0x10/0x11/0x12/0x13 -> grant order 0,1,2,3,0; each start pulse at least 1 cycle after tx_busy falls.
REQ-037 Timeout: tx_busy stuck at 0, BUSY_TO=16 -> err_timeout=1 exactly 16 cycles after START, byte_count=0, FSM back in IDLE.
REQ-038 Enable: en drops in WAIT_LO with req=0011 -> current byte completes, no further tx_start while en=0, grants resume at the next index when en=1.
REQ-039 Reset mid-operation: rst in WAIT_LO -> all outputs at reset values next cycle; with req=1000, the first grant after reset goes to 3; with req=1001, it goes to 0.
REQ-040 Wrap-around: preload 65535 bytes (or force byte_count=0xFFFF), send one more byte -> byte_count=0x0000.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that feeds one byte at a time from four requesters into a UART transmitter,
// handshaking on tx_busy and flagging a sticky error if the transmitter never responds.
module uart_tx_arbiter #(
  parameter int BUSY_TO = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [3:0]  req,
  input  logic [31:0] req_data,
  input  logic        tx_busy,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  output logic [3:0]  ack,
  output logic [1:0]  grant_id,
  output logic        arb_busy,
  output logic        err_timeout,
  output logic [15:0] byte_count
);

  localparam int CW = (BUSY_TO > 1) ? $clog2(BUSY_TO) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(BUSY_TO - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    WAIT_HI = 3'd2,
    WAIT_LO = 3'd3,
    GAP     = 3'd4
  } state_t;

  state_t          state;
  logic [CW-1:0]   to_cnt;
  logic [1:0]      pick;
  logic            pick_valid;
  logic [1:0]      rr_idx;

  // grant_id doubles as the last-grant pointer; the search starts one past it and wraps
  always_comb begin
    pick       = grant_id;
    pick_valid = 1'b0;
    rr_idx     = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      rr_idx = grant_id + 2'(i);
      if (!pick_valid && req[rr_idx]) begin
        pick       = rr_idx;
        pick_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      to_cnt      <= '0;
      tx_data     <= 8'h00;
      tx_start    <= 1'b0;
      ack         <= 4'b0000;
      grant_id    <= 2'd3;
      arb_busy    <= 1'b0;
      err_timeout <= 1'b0;
      byte_count  <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (en && pick_valid) begin
            tx_data  <= req_data[{pick, 3'b000} +: 8];
            tx_start <= 1'b1;
            ack      <= 4'b0001 << pick;
            grant_id <= pick;
            arb_busy <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          tx_start <= 1'b0;
          ack      <= 4'b0000;
          to_cnt   <= '0;
          state    <= WAIT_HI;
        end
        WAIT_HI: begin
          if (tx_busy) begin
            state <= WAIT_LO;
          end else if (to_cnt == TO_LAST) begin
            err_timeout <= 1'b1;
            arb_busy    <= 1'b0;
            state       <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        WAIT_LO: begin
          if (!tx_busy) begin
            byte_count <= byte_count + 16'd1;
            state      <= GAP;
          end
        end
        GAP: begin
          arb_busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          tx_start <= 1'b0;
          ack      <= 4'b0000;
          arb_busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  // At most one requester may ever see its byte taken, and a start pulse always names one
  assert property (@(posedge clk) disable iff (rst) $onehot0(ack));
  assert property (@(posedge clk) disable iff (rst) tx_start |-> (ack != 4'b0000));

endmodule
